// File: rtl/shift_sequencer_pkg.sv
// Shared opcode and FSM state encodings for the shift sequencer and its barrel shifter.
package shift_sequencer_pkg;

   localparam logic [3:0] OP_LSL = 4'b0100;
   localparam logic [3:0] OP_LSR = 4'b0000;
   localparam logic [3:0] OP_ASR = 4'b0001;
   localparam logic [3:0] OP_ROR = 4'b0010;
   localparam logic [3:0] OP_RRX = 4'b1010;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_PASS = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

endpackage

// File: rtl/shift_sequencer_barrel_shifter.sv
// Combinational single-pass shifter: 1..31 bit LSL/LSR/ASR/ROR or RRX, with ARM carry-out.
module barrel_shifter
   import shift_sequencer_pkg::*;
(
   input  logic [31:0] data_in,
   input  logic [4:0]  shift_amount,
   input  logic [3:0]  opcode,
   input  logic        cf_in,
   input  logic        instr_exec_in,
   output logic [31:0] data_out,
   output logic        cf_out
);

   logic [63:0] wide;

   always_comb begin
      data_out = data_in;
      cf_out   = cf_in;
      wide     = '0;
      // Zero amount leaves value and carry untouched; RRX ignores the amount entirely.
      if (instr_exec_in && (shift_amount != 5'd0 || opcode == OP_RRX)) begin
         case (opcode)
            OP_LSL: begin
               wide     = {32'd0, data_in} << shift_amount;
               data_out = wide[31:0];
               cf_out   = wide[32];
            end
            OP_LSR: begin
               wide     = {data_in, 32'd0} >> shift_amount;
               data_out = wide[63:32];
               cf_out   = wide[31];
            end
            OP_ASR: begin
               wide     = $signed({data_in, 32'd0}) >>> shift_amount;
               data_out = wide[63:32];
               cf_out   = wide[31];
            end
            OP_ROR: begin
               wide     = {data_in, data_in} >> shift_amount;
               data_out = wide[31:0];
               cf_out   = wide[31];
            end
            OP_RRX: begin
               data_out = {cf_in, data_in[31:1]};
               cf_out   = data_in[0];
            end
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/shift_sequencer.sv
// Multi-pass controller splitting register-specified shifts into passes of at most MAX_STEP bits.
module shift_sequencer
   import shift_sequencer_pkg::*;
#(
   parameter int MAX_STEP = 31,
   parameter int AMT_W    = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      in_data,
   input  logic [AMT_W-1:0] in_amt,
   input  logic [3:0]       in_opcode,
   input  logic             in_cf,
   input  logic             in_exec,
   input  logic             flush,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [31:0]      out_data,
   output logic             out_cf,
   output logic             busy
);

   localparam logic [5:0] STEP_MAX = 6'(MAX_STEP);

   logic [1:0]  state;
   logic [31:0] work;
   logic        carry;
   logic [3:0]  op;
   logic [5:0]  rem;
   logic [5:0]  eff;
   logic        ror_mult;
   logic [4:0]  step;
   logic [31:0] sh_data;
   logic        sh_cf;
   logic        accept;

   assign in_ready  = (state == S_IDLE) && !flush && !rst;
   assign accept    = in_valid && in_ready;
   assign out_valid = (state == S_DONE);
   assign busy      = (state != S_IDLE);
   assign out_data  = work;
   assign out_cf    = carry;

   // Effective amount; clamping LSL/LSR to 33 and ASR to 32 lets the pass chain produce the boundary results.
   always_comb begin
      eff      = '0;
      ror_mult = 1'b0;
      case (in_opcode)
         OP_LSL, OP_LSR: eff = (in_amt > AMT_W'(33)) ? 6'd33 : 6'(in_amt);
         OP_ASR:         eff = (in_amt > AMT_W'(32)) ? 6'd32 : 6'(in_amt);
         OP_ROR: begin
            eff      = {1'b0, in_amt[4:0]};
            ror_mult = (in_amt != '0) && (in_amt[4:0] == 5'd0);
         end
         OP_RRX:         eff = 6'd1;
         default:        eff = '0;
      endcase
      if (!in_exec) begin
         eff      = '0;
         ror_mult = 1'b0;
      end
   end

   assign step = (rem > STEP_MAX) ? STEP_MAX[4:0] : rem[4:0];

   barrel_shifter u_shifter (
      .data_in       (work),
      .shift_amount  (step),
      .opcode        (op),
      .cf_in         (carry),
      .instr_exec_in (1'b1),
      .data_out      (sh_data),
      .cf_out        (sh_cf)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= S_IDLE;
         work  <= '0;
         carry <= 1'b0;
         op    <= '0;
         rem   <= '0;
      end else if (flush) begin
         state <= S_IDLE;
      end else begin
         case (state)
            S_IDLE: begin
               if (accept) begin
                  work <= in_data;
                  op   <= in_opcode;
                  rem  <= eff;
                  if (ror_mult) begin
                     carry <= in_data[31];
                     state <= S_DONE;
                  end else begin
                     carry <= in_cf;
                     state <= (eff == 6'd0) ? S_DONE : S_PASS;
                  end
               end
            end
            S_PASS: begin
               work  <= sh_data;
               carry <= sh_cf;
               rem   <= rem - {1'b0, step};
               if (rem == {1'b0, step}) state <= S_DONE;
            end
            S_DONE: begin
               if (out_ready) state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule
